dbg_mem_loader: RTL and testbench
=================================

Name: dbg_mem_loader

Overview:
- Hardware replacement for the force-based debug programming sequence.
- Accepts a byte stream (from UART RX), parses load frames and drives the SoC debug memory port (dbg_mem_op/dbg_adr/dbg_do/dbg_wren).
- Holds the CPU in reset while loading and releases it on a RUN command.
- Generalised in address/data width, burst length and bus hold time.

Parameters:
- ADR_W, 32, debug address width; multiple of 8.
- DATA_W, 32, debug data width; multiple of 8, ≤ 64.
- LEN_W, 16, word-count field width; multiple of 8.
- HOLD_CYCLES, 2, cycles each write is held on the debug bus; ≥ 1.

Ports:
- clk  in  1  system clock
- n_reset  in  1  synchronous active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid & in_ready on a clk edge
- dbg_mem_op  out  1  debug bus owns memory
- dbg_adr  out  ADR_W  debug byte address
- dbg_do  out  DATA_W  debug write data
- dbg_wren  out  DATA_W/8  byte write enables
- dbg_di  in  DATA_W  debug read data (used only with verify)
- cpu_n_reset  out  1  CPU reset, active low
- busy  out  1  frame in progress
- err  out  1  sticky protocol/verify error

Behaviour:
- One clock, reset is synchronous and active-low: all state sampled on the clk rising edge; n_reset=0 forces reset regardless of other inputs.
- Reset values:
  - state=IDLE, cpu_n_reset=0 (CPU held), dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, err=0, busy=0, in_ready=1.
- Frame format (multi-byte fields little-endian):
  - 0xA5 magic, cmd byte.
  - cmd 0x01 WRITE: ADR_W/8 address bytes, LEN_W/8 word-count bytes, then count×DATA_W/8 data bytes.
  - cmd 0x02 RUN: no payload.
- States and transitions:
  - IDLE: accepts bytes. 0xA5 → CMD. Any other byte is dropped, stays IDLE.
  - CMD:
    - 0x01 → ADDR; cpu_n_reset driven 0 and err cleared on the same edge.
    - 0x02 → RUN.
    - Any other value → err=1, IDLE.
  - ADDR, LEN: shift in bytes with an internal byte counter.
    - LEN done with count=0 → IDLE, no bus activity.
    - LEN done with count>0 → DATA.
  - DATA: assemble one word. The last byte of the word → WRITE.
  - WRITE (in_ready=0):
    - dbg_mem_op=1, dbg_wren all ones, dbg_adr/dbg_do stable for exactly HOLD_CYCLES cycles.
    - Then: address += DATA_W/8 (wraps modulo 2^ADR_W) and count -= 1.
    - count≠0 → DATA; else → IDLE.
  - RUN: cpu_n_reset=1 on the next edge → IDLE. cpu_n_reset stays 1 until a later WRITE cmd or n_reset.
- in_ready=1 in IDLE/CMD/ADDR/LEN/DATA, 0 in WRITE/VERIFY/RUN.
- busy=1 in every state except IDLE.
- Outside WRITE/VERIFY:
  - dbg_mem_op=0, dbg_wren=0.
  - dbg_adr/dbg_do hold their last values.
- in_valid low mid-frame: parser waits indefinitely, no timeout.
- n_reset low mid-WRITE: bus released on that edge (dbg_wren=0, dbg_mem_op=0), CPU held in reset, frame discarded.
- A second 0xA5 inside a payload is treated as data, not resync.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- With the macro defined, WRITE is followed by VERIFY:
  - 1 cycle of dbg_mem_op=1, dbg_wren=0, same dbg_adr.
  - 1 cycle later dbg_di is compared with the written word.
  - Mismatch: err=1, frame aborted → IDLE, remaining bytes of the frame are parsed as IDLE garbage.
  - Match: continue as normal.
- Without the macro: dbg_di is ignored, there is no VERIFY state, and WRITE goes directly to the next state.

Test Plan:
- Reset, then WRITE frame A5 01 00 00 00 00 | 01 00 | AA 00 00 00 → one write cycle group: dbg_adr=0x00000, dbg_do=0xAA, dbg_wren=0xF held 2 cycles, cpu_n_reset stays 0.
- WRITE at 0x20000, count=7, words 0x00000537, 0x00052583, 0x00010537, 0x00052583, 0x00020537, 0x02052583, 0x0000006f → seven writes at 0x20000..0x20018 step 4; then A5 02 → cpu_n_reset=1.
- Address wrap: WRITE at 0xFFFFFFFC, count=2 → writes to 0xFFFFFFFC then 0x00000000.
- Protocol: bytes 11 22 A5 07 → 11/22 dropped, err=1, IDLE; then a valid WRITE clears err.
- Count=0 frame → no dbg_wren activity, busy returns 0. in_valid deasserted for 50 cycles mid-data → output unchanged, completes correctly after resume.
- Verify build (LOADER_VERIFY_EN): memory model returns 0xBB for a write of 0xCC → err=1, later data words not written. Non-verify build: same stimulus → err=0.

Source files
------------

// File: rtl/dbg_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : dbg_mem_loader
// Purpose  : Parses A5-framed load/run commands from a byte stream and drives
//            the SoC debug memory port; holds the CPU in reset while loading.
//            Optional read-back check of every write: define LOADER_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_mem_loader #(
    parameter int ADR_W       = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                dbg_mem_op,
    output logic [ADR_W-1:0]    dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    output logic [DATA_W/8-1:0] dbg_wren,
    input  logic [DATA_W-1:0]   dbg_di,
    output logic                cpu_n_reset,
    output logic                busy,
    output logic                err
);

    localparam logic [7:0] c_MAGIC     = 8'hA5;
    localparam logic [7:0] c_CMD_WRITE = 8'h01;
    localparam logic [7:0] c_CMD_RUN   = 8'h02;

    localparam logic [7:0] c_ADR_LAST  = 8'(ADR_W / 8 - 1);
    localparam logic [7:0] c_LEN_LAST  = 8'(LEN_W / 8 - 1);
    localparam logic [7:0] c_DAT_LAST  = 8'(DATA_W / 8 - 1);
    localparam logic [ADR_W-1:0] c_ADR_STEP = ADR_W'(DATA_W / 8);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD    = 3'd1;
    localparam logic [2:0] c_ST_ADDR   = 3'd2;
    localparam logic [2:0] c_ST_LEN    = 3'd3;
    localparam logic [2:0] c_ST_DATA   = 3'd4;
    localparam logic [2:0] c_ST_WRITE  = 3'd5;
    localparam logic [2:0] c_ST_VERIFY = 3'd6;
    localparam logic [2:0] c_ST_RUN    = 3'd7;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [7:0]          r_bcnt;
    logic [ADR_W-1:0]    r_addr;
    logic [LEN_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_word;
    logic [c_HOLD_W-1:0] r_hold;
    logic [ADR_W-1:0]    r_dbg_adr;
    logic [DATA_W-1:0]   r_dbg_do;
    logic                r_cpu_n_reset;
    logic                r_err;

    logic                w_in_ready;
    logic                w_bus_own;
    logic                w_wren;
    logic                w_fire;
    logic                w_hold_done;
    logic [LEN_W-1:0]    w_count_dec;

    // Little-endian fields: each new byte enters at the top and shifts down,
    // so after the last byte the first one received sits in bits [7:0].
    logic [ADR_W+7:0]    w_addr_cat;
    logic [LEN_W+7:0]    w_len_cat;
    logic [DATA_W+7:0]   w_word_cat;
    logic [ADR_W-1:0]    w_addr_shift;
    logic [LEN_W-1:0]    w_len_shift;
    logic [DATA_W-1:0]   w_word_shift;

    assign w_addr_cat   = {in_data, r_addr};
    assign w_len_cat    = {in_data, r_count};
    assign w_word_cat   = {in_data, r_word};
    assign w_addr_shift = w_addr_cat[ADR_W+7:8];
    assign w_len_shift  = w_len_cat[LEN_W+7:8];
    assign w_word_shift = w_word_cat[DATA_W+7:8];

    assign w_fire      = in_valid & w_in_ready;
    assign w_hold_done = (r_hold == c_HOLD_LAST);
    assign w_count_dec = r_count - LEN_W'(1);

`ifdef LOADER_VERIFY_EN
    logic r_vphase;
    logic w_mismatch;
    assign w_mismatch = (dbg_di != r_dbg_do);
`else
    logic w_unused_di;
    assign w_unused_di = ^dbg_di;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_bus_own   = 1'b0;
        w_wren      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_in_ready = 1'b1;
                if (w_fire && in_data == c_MAGIC) w_state_nxt = c_ST_CMD;
            end
            c_ST_CMD: begin
                w_in_ready = 1'b1;
                if (w_fire) begin
                    if (in_data == c_CMD_WRITE)    w_state_nxt = c_ST_ADDR;
                    else if (in_data == c_CMD_RUN) w_state_nxt = c_ST_RUN;
                    else                           w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_ADDR: begin
                w_in_ready = 1'b1;
                if (w_fire && r_bcnt == c_ADR_LAST) w_state_nxt = c_ST_LEN;
            end
            c_ST_LEN: begin
                w_in_ready = 1'b1;
                if (w_fire && r_bcnt == c_LEN_LAST)
                    w_state_nxt = (w_len_shift == '0) ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                w_in_ready = 1'b1;
                if (w_fire && r_bcnt == c_DAT_LAST) w_state_nxt = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                w_bus_own = 1'b1;
                w_wren    = 1'b1;
                if (w_hold_done) begin
`ifdef LOADER_VERIFY_EN
                    w_state_nxt = c_ST_VERIFY;
`else
                    w_state_nxt = (w_count_dec == '0) ? c_ST_IDLE : c_ST_DATA;
`endif
                end
            end
            c_ST_VERIFY: begin
                w_bus_own = 1'b1;
`ifdef LOADER_VERIFY_EN
                // Phase 0 presents the read, phase 1 sees the registered data.
                if (r_vphase) begin
                    if (w_mismatch || r_count == '0) w_state_nxt = c_ST_IDLE;
                    else                             w_state_nxt = c_ST_DATA;
                end
`else
                w_state_nxt = c_ST_IDLE;
`endif
            end
            c_ST_RUN: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_bcnt        <= '0;
            r_addr        <= '0;
            r_count       <= '0;
            r_word        <= '0;
            r_hold        <= '0;
            r_dbg_adr     <= '0;
            r_dbg_do      <= '0;
            r_cpu_n_reset <= 1'b0;
            r_err         <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_vphase      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_bcnt <= '0;
                end
                c_ST_CMD: begin
                    r_bcnt <= '0;
                    if (w_fire) begin
                        if (in_data == c_CMD_WRITE) begin
                            r_cpu_n_reset <= 1'b0;
                            r_err         <= 1'b0;
                        end else if (in_data != c_CMD_RUN) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_ADDR: begin
                    if (w_fire) begin
                        r_addr <= w_addr_shift;
                        r_bcnt <= (r_bcnt == c_ADR_LAST) ? 8'd0 : r_bcnt + 8'd1;
                    end
                end
                c_ST_LEN: begin
                    if (w_fire) begin
                        r_count <= w_len_shift;
                        r_bcnt  <= (r_bcnt == c_LEN_LAST) ? 8'd0 : r_bcnt + 8'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_fire) begin
                        r_word <= w_word_shift;
                        if (r_bcnt == c_DAT_LAST) begin
                            r_bcnt    <= 8'd0;
                            r_dbg_adr <= r_addr;
                            r_dbg_do  <= w_word_shift;
                            r_hold    <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 8'd1;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (w_hold_done) begin
                        // dbg_adr keeps the written address; r_addr moves on.
                        r_addr  <= r_addr + c_ADR_STEP;
                        r_count <= w_count_dec;
                        r_hold  <= '0;
`ifdef LOADER_VERIFY_EN
                        r_vphase <= 1'b0;
`endif
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end
                c_ST_VERIFY: begin
`ifdef LOADER_VERIFY_EN
                    r_vphase <= 1'b1;
                    if (r_vphase && w_mismatch) r_err <= 1'b1;
`endif
                end
                c_ST_RUN: begin
                    r_cpu_n_reset <= 1'b1;
                end
                default: begin
                    r_bcnt <= '0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign busy        = (r_state != c_ST_IDLE);
    assign dbg_mem_op  = w_bus_own;
    assign dbg_wren    = {(DATA_W/8){w_wren}};
    assign dbg_adr     = r_dbg_adr;
    assign dbg_do      = r_dbg_do;
    assign cpu_n_reset = r_cpu_n_reset;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dbg_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_mem_loader
// Purpose  : Scoreboard bench for dbg_mem_loader: frames are driven byte by
//            byte, expected bus writes are queued and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_mem_loader;

    localparam int c_ADR_W  = 32;
    localparam int c_DATA_W = 32;
    localparam int c_LEN_W  = 16;
    localparam int c_HOLD   = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        dbg_mem_op;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_di;
    logic        cpu_n_reset;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] wbuf [16];
    logic [31:0] mem  [256];
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    dbg_mem_loader #(
        .ADR_W      (c_ADR_W),
        .DATA_W     (c_DATA_W),
        .LEN_W      (c_LEN_W),
        .HOLD_CYCLES(c_HOLD)
    ) u_dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dbg_mem_op (dbg_mem_op),
        .dbg_adr    (dbg_adr),
        .dbg_do     (dbg_do),
        .dbg_wren   (dbg_wren),
        .dbg_di     (dbg_di),
        .cpu_n_reset(cpu_n_reset),
        .busy       (busy),
        .err        (err)
    );

    // Memory model: a written 0xCC is stored as 0xBB to provoke a read-back error.
    always @(posedge clk) begin
        if (dbg_wren != 4'h0)
            mem[dbg_adr[9:2]] <= (dbg_do == 32'hCC) ? 32'hBB : dbg_do;
        if (dbg_mem_op && dbg_wren == 4'h0)
            rd_q <= mem[dbg_adr[9:2]];
    end
    assign dbg_di = rd_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: collapse each run of write cycles into one transaction.
    initial begin : monitor
        int          run;
        logic [31:0] cap_adr;
        logic [31:0] cap_do;
        logic [3:0]  cap_wren;
        logic        cap_op;
        logic        unstable;
        wr_t         e;
        run = 0;
        unstable = 1'b0;
        forever begin
            @(negedge clk);
            if (dbg_wren != 4'h0) begin
                if (run == 0) begin
                    cap_adr  = dbg_adr;
                    cap_do   = dbg_do;
                    cap_wren = dbg_wren;
                    cap_op   = dbg_mem_op;
                    unstable = 1'b0;
                end else if (dbg_adr != cap_adr || dbg_do != cap_do) begin
                    unstable = 1'b1;
                end
                run++;
            end else if (run != 0) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_adr", {32'h0, cap_adr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_adr",    {32'h0, cap_adr}, {32'h0, e.adr});
                    check("wr_data",   {32'h0, cap_do},  {32'h0, e.dat});
                    check("wr_wren",   {60'h0, cap_wren}, 64'hF);
                    check("wr_mem_op", {63'h0, cap_op},   64'h1);
                    check("wr_hold",   64'(run),          64'(c_HOLD));
                    check("wr_stable", {63'h0, unstable}, 64'h0);
                end
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int tmo;
        in_data  = b;
        in_valid = 1'b1;
        tmo = 0;
        while (!in_ready && tmo < 1000) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 1000) check("in_ready_timeout", {63'h0, in_ready}, 64'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_write(input logic [31:0] adr, input int n, input bit push);
        wr_t e;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_word(adr);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            if (push) begin
                e.adr = adr + 32'(4 * i);
                e.dat = wbuf[i];
                exp_q.push_back(e);
            end
            send_word(wbuf[i]);
        end
    endtask

    task automatic wait_idle();
        int tmo;
        tmo = 0;
        @(negedge clk);
        while (busy && tmo < 2000) begin
            @(negedge clk);
            tmo++;
        end
        check("idle", {63'h0, busy}, 64'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int   w0;
        wr_t  e;
        n_reset  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",     {63'h0, busy},        64'h0);
        check("rst_in_ready", {63'h0, in_ready},    64'h1);
        check("rst_cpu",      {63'h0, cpu_n_reset}, 64'h0);
        check("rst_err",      {63'h0, err},         64'h0);
        check("rst_mem_op",   {63'h0, dbg_mem_op},  64'h0);
        check("rst_wren",     {60'h0, dbg_wren},    64'h0);
        check("rst_adr",      {32'h0, dbg_adr},     64'h0);
        check("rst_do",       {32'h0, dbg_do},      64'h0);
        n_reset = 1'b1;
        @(negedge clk);

        // Single-word write at 0
        wbuf[0] = 32'h0000_00AA;
        send_write(32'h0, 1, 1'b1);
        wait_idle();
        check("t1_cpu", {63'h0, cpu_n_reset}, 64'h0);

        // Seven-word program at 0x20000, then RUN
        wbuf[0] = 32'h0000_0537; wbuf[1] = 32'h0005_2583; wbuf[2] = 32'h0001_0537;
        wbuf[3] = 32'h0005_2583; wbuf[4] = 32'h0002_0537; wbuf[5] = 32'h0205_2583;
        wbuf[6] = 32'h0000_006F;
        send_write(32'h0002_0000, 7, 1'b1);
        wait_idle();
        check("t2_cpu_held", {63'h0, cpu_n_reset}, 64'h0);
        send_byte(8'hA5);
        send_byte(8'h02);
        wait_idle();
        check("t2_cpu_run", {63'h0, cpu_n_reset}, 64'h1);

        // Address wrap; a WRITE command re-asserts CPU reset
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        send_write(32'hFFFF_FFFC, 2, 1'b1);
        wait_idle();
        check("t3_cpu_held", {63'h0, cpu_n_reset}, 64'h0);

        // Protocol error: garbage then bad command
        send_byte(8'h11);
        check("t4_drop_busy", {63'h0, busy}, 64'h0);
        send_byte(8'h22);
        send_byte(8'hA5);
        send_byte(8'h07);
        wait_idle();
        check("t4_err_set", {63'h0, err}, 64'h1);
        wbuf[0] = 32'h1234_5678;
        send_write(32'h0000_0100, 1, 1'b1);
        wait_idle();
        check("t4_err_clr", {63'h0, err}, 64'h0);

        // Count = 0: no bus activity
        w0 = n_writes;
        send_write(32'h0000_0040, 0, 1'b1);
        wait_idle();
        check("t5_no_write", 64'(n_writes - w0), 64'h0);

        // Stall mid-data; the word also carries A5 bytes that must stay data
        send_byte(8'hA5);
        send_byte(8'h01);
        send_word(32'h0000_0080);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (50) @(negedge clk);
        check("t6_stall_wren",  {60'h0, dbg_wren}, 64'h0);
        check("t6_stall_busy",  {63'h0, busy},     64'h1);
        check("t6_stall_do",    {32'h0, dbg_do},   64'h1234_5678);
        check("t6_stall_adr",   {32'h0, dbg_adr},  64'h100);
        e.adr = 32'h80;
        e.dat = 32'hA5A5_01A5;
        exp_q.push_back(e);
        send_byte(8'hA5);
        send_byte(8'hA5);
        wait_idle();

        // Read-back check: memory corrupts 0xCC into 0xBB
        wbuf[0] = 32'hCC; wbuf[1] = 32'hDD; wbuf[2] = 32'hEE;
`ifdef LOADER_VERIFY_EN
        e.adr = 32'h200;
        e.dat = 32'hCC;
        exp_q.push_back(e);
        send_write(32'h0000_0200, 3, 1'b0);
        wait_idle();
        check("t7_err", {63'h0, err}, 64'h1);
`else
        send_write(32'h0000_0200, 3, 1'b1);
        wait_idle();
        check("t7_err", {63'h0, err}, 64'h0);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
